// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end.
// Queue entry layout, FSM states and PC step sizes.
package fetch_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        comp;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_FAULT
  } state_t;

  localparam logic [63:0] INST_STEP_C = 64'd2;
  localparam logic [63:0] INST_STEP_N = 64'd4;

endpackage

// File: rtl/fetch_queue.sv
// In-order buffer between the cache and decode.
// Flush beats push and pop; push is dropped when full.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(QDEPTH);

  fetch_entry_t    mem [QDEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(QDEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, talks to the I-cache,
// buffers instructions for decode, handles redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_1000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        fence_i,
  output logic [63:0] ic_pc,
  output logic        ic_invalid,
  input  logic        ic_inst_valid,
  input  logic [31:0] ic_inst,
  input  logic        ic_inst_comp,
  input  logic        page_fault,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_comp,
  output logic        out_fault
);

  state_t       state_q;
  state_t       state_d;
  logic [63:0]  pc_q;
  logic [63:0]  pc_d;
  logic         push;
  logic         flush;
  logic         full;
  logic         empty;
  fetch_entry_t entry;
  fetch_entry_t head;

  assign ic_pc      = {pc_q[63:1], 1'b0};
  assign ic_invalid = (state_q == S_FLUSH);
  assign out_valid  = ~empty;
  assign out_pc     = head.pc;
  assign out_inst   = head.inst;
  assign out_comp   = head.comp;
  assign out_fault  = head.fault;

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state, next PC and queue control.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    entry   = '0;
    if (fence_i) begin
      flush   = 1'b1;
      pc_d    = redirect_pc & ~64'h1;
      state_d = S_FLUSH;
    end else if (redirect) begin
      flush   = 1'b1;
      pc_d    = redirect_pc & ~64'h1;
      state_d = S_RUN;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (!full && page_fault) begin
            push        = 1'b1;
            entry.pc    = pc_q;
            entry.fault = 1'b1;
            state_d     = S_FAULT;
          end else if (!full && ic_inst_valid) begin
            push       = 1'b1;
            entry.pc   = pc_q;
            entry.inst = ic_inst;
            entry.comp = ic_inst_comp;
            pc_d = pc_q + (ic_inst_comp ? INST_STEP_C
                                        : INST_STEP_N);
          end
        end
        S_FLUSH: state_d = S_RUN;
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_RUN;
      endcase
    end
  end

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (out_valid & out_ready),
    .flush(flush),
    .din  (entry),
    .full (full),
    .empty(empty),
    .head (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit.
// Expected entries queued with stimulus, checked on pop.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        fence_i;
  logic [63:0] ic_pc;
  logic        ic_invalid;
  logic        ic_inst_valid;
  logic [31:0] ic_inst;
  logic        ic_inst_comp;
  logic        page_fault;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_comp;
  logic        out_fault;

  logic        hit;
  logic        pf;
  logic [63:0] comp_addr;

  fetch_entry_t sb[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC(64'h1000),
    .QDEPTH  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .fence_i      (fence_i),
    .ic_pc        (ic_pc),
    .ic_invalid   (ic_invalid),
    .ic_inst_valid(ic_inst_valid),
    .ic_inst      (ic_inst),
    .ic_inst_comp (ic_inst_comp),
    .page_fault   (page_fault),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_comp     (out_comp),
    .out_fault    (out_fault)
  );

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return {a[15:0] ^ 16'h5a5a, a[15:0]};
  endfunction

  function automatic fetch_entry_t mk(input logic [63:0] a,
                                      input logic c,
                                      input logic f);
    fetch_entry_t e;
    e.pc    = a;
    e.inst  = f ? 32'h0 : inst_of(a);
    e.comp  = f ? 1'b0 : c;
    e.fault = f;
    return e;
  endfunction

  // Cache model: always-hit data derived from the address.
  assign ic_inst_valid = hit;
  assign page_fault    = pf;
  assign ic_inst       = inst_of(ic_pc);
  assign ic_inst_comp  = (ic_pc == comp_addr);

  // Scoreboard: compare each accepted head with the oldest expectation.
  always @(negedge clk) begin
    fetch_entry_t got;
    fetch_entry_t exp;
    if (rst_n && out_valid && out_ready && !redirect && !fence_i) begin
      got = '{out_pc, out_inst, out_comp, out_fault};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected got pc=%h inst=%h", out_pc, out_inst);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL pop_entry got pc=%h inst=%h c=%b f=%b exp pc=%h inst=%h c=%b f=%b",
                   got.pc, got.inst, got.comp, got.fault,
                   exp.pc, exp.inst, exp.comp, exp.fault);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    hit         = 1'b0;
    pf          = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    fence_i     = 1'b0;
    out_ready   = 1'b0;
    comp_addr   = '1;
    sb.delete();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    hit         = 1'b0;
    pf          = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    fence_i     = 1'b0;
    out_ready   = 1'b0;
    comp_addr   = '1;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (ic_pc !== 64'h1000) begin
      failures++; $display("FAIL rst_ic_pc got=%h exp=1000", ic_pc);
    end
    checks++;
    if (ic_invalid !== 1'b0) begin
      failures++; $display("FAIL rst_invalid got=%b exp=0", ic_invalid);
    end
    checks++;
    if ({out_pc, out_inst, out_comp, out_fault} !== '0) begin
      failures++;
      $display("FAIL rst_outs got pc=%h inst=%h c=%b f=%b exp all 0",
               out_pc, out_inst, out_comp, out_fault);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_seq_mix();
    do_reset();
    comp_addr = 64'h1004;
    out_ready = 1'b1;
    sb.push_back(mk(64'h1000, 1'b0, 1'b0));
    sb.push_back(mk(64'h1004, 1'b1, 1'b0));
    sb.push_back(mk(64'h1006, 1'b0, 1'b0));
    hit = 1'b1;
    tick(3);
    hit = 1'b0;
    checks++;
    if (ic_pc !== 64'h100a) begin
      failures++; $display("FAIL seq_pc got=%h exp=100a", ic_pc);
    end
    tick(2);
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL seq_drain left=%0d valid=%b exp 0/0", sb.size(), out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    hit = 1'b1;
    tick(4);
    checks++;
    if (ic_pc !== 64'h1008) begin
      failures++; $display("FAIL bp_pc_stall got=%h exp=1008", ic_pc);
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h1000) begin
      failures++;
      $display("FAIL bp_head got valid=%b pc=%h exp 1/1000", out_valid, out_pc);
    end
    sb.push_back(mk(64'h1000, 1'b0, 1'b0));
    sb.push_back(mk(64'h1004, 1'b0, 1'b0));
    sb.push_back(mk(64'h1008, 1'b0, 1'b0));
    sb.push_back(mk(64'h100c, 1'b0, 1'b0));
    out_ready = 1'b1;
    tick(1);
    checks++;
    if (ic_pc !== 64'h1008) begin
      failures++; $display("FAIL bp_full_pop got=%h exp=1008", ic_pc);
    end
    tick(2);
    hit = 1'b0;
    tick(3);
    checks++;
    if (ic_pc !== 64'h1010) begin
      failures++; $display("FAIL bp_resume_pc got=%h exp=1010", ic_pc);
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain left=%0d valid=%b exp 0/0", sb.size(), out_valid);
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    hit = 1'b1;
    tick(3);
    redirect    = 1'b1;
    redirect_pc = 64'h2003;
    tick(1);
    redirect = 1'b0;
    hit      = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rd_cleared got=%b exp=0", out_valid);
    end
    checks++;
    if (ic_pc !== 64'h2002) begin
      failures++; $display("FAIL rd_ic_pc got=%h exp=2002", ic_pc);
    end
    sb.push_back(mk(64'h2002, 1'b0, 1'b0));
    out_ready = 1'b1;
    hit       = 1'b1;
    tick(1);
    hit = 1'b0;
    tick(2);
    checks++;
    if (sb.size() != 0 || ic_pc !== 64'h2006) begin
      failures++;
      $display("FAIL rd_resume left=%0d pc=%h exp 0/2006", sb.size(), ic_pc);
    end
  endtask

  task automatic test_fence();
    checks++;
    if (ic_invalid !== 1'b0) begin
      failures++; $display("FAIL fi_idle got=%b exp=0", ic_invalid);
    end
    fence_i     = 1'b1;
    redirect_pc = 64'h3000;
    hit         = 1'b1;
    out_ready   = 1'b1;
    tick(1);
    fence_i = 1'b0;
    checks++;
    if (ic_invalid !== 1'b1 || ic_pc !== 64'h3000) begin
      failures++;
      $display("FAIL fi_pulse got inv=%b pc=%h exp 1/3000", ic_invalid, ic_pc);
    end
    tick(1);
    checks++;
    if (ic_invalid !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL fi_one_cycle got inv=%b valid=%b exp 0/0", ic_invalid, out_valid);
    end
    sb.push_back(mk(64'h3000, 1'b0, 1'b0));
    tick(1);
    hit = 1'b0;
    tick(2);
    checks++;
    if (sb.size() != 0 || ic_pc !== 64'h3004) begin
      failures++;
      $display("FAIL fi_resume left=%0d pc=%h exp 0/3004", sb.size(), ic_pc);
    end
    fence_i     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 64'h3100;
    tick(1);
    fence_i  = 1'b0;
    redirect = 1'b0;
    checks++;
    if (ic_invalid !== 1'b1 || ic_pc !== 64'h3100) begin
      failures++;
      $display("FAIL fi_both got inv=%b pc=%h exp 1/3100", ic_invalid, ic_pc);
    end
    tick(1);
    checks++;
    if (ic_invalid !== 1'b0) begin
      failures++; $display("FAIL fi_both_end got=%b exp=0", ic_invalid);
    end
  endtask

  task automatic test_page_fault();
    do_reset();
    out_ready = 1'b1;
    hit       = 1'b1;
    sb.push_back(mk(64'h1000, 1'b0, 1'b0));
    sb.push_back(mk(64'h1004, 1'b0, 1'b0));
    tick(2);
    pf = 1'b1;
    sb.push_back(mk(64'h1008, 1'b0, 1'b1));
    tick(1);
    pf = 1'b0;
    tick(4);
    checks++;
    if (ic_pc !== 64'h1008 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL pf_halt got pc=%h valid=%b exp 1008/0", ic_pc, out_valid);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL pf_entries left=%0d exp=0", sb.size());
    end
    redirect    = 1'b1;
    redirect_pc = 64'h4000;
    tick(1);
    redirect = 1'b0;
    sb.push_back(mk(64'h4000, 1'b0, 1'b0));
    tick(1);
    hit = 1'b0;
    tick(2);
    checks++;
    if (sb.size() != 0 || ic_pc !== 64'h4004) begin
      failures++;
      $display("FAIL pf_resume left=%0d pc=%h exp 0/4004", sb.size(), ic_pc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 64'h1230;
    tick(1);
    redirect = 1'b0;
    hit      = 1'b1;
    tick(1);
    hit = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ic_pc !== 64'h1234) begin
      failures++;
      $display("FAIL mid_setup got valid=%b pc=%h exp 1/1234", out_valid, ic_pc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ic_pc !== 64'h1000 || ic_invalid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got valid=%b pc=%h inv=%b exp 0/1000/0",
               out_valid, ic_pc, ic_invalid);
    end
    #1;
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_n = 1'b1;
    test_reset();
    test_seq_mix();
    test_backpressure();
    test_redirect_full();
    test_fence();
    test_page_fault();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end stage that owns the fetch PC, drives the `pc` input of the instruction cache, and consumes its `inst_valid`/`inst`/`inst_comp` outputs.
- Accepted instructions are buffered in a small in-order queue and handed to decode with a valid/ready handshake.
- Handles control-flow redirects, `fence.i` (cache invalidation), and instruction page faults.

Parameters:
- RESET_PC, 64'h0000_0000_0000_1000, PC loaded on reset.
- QDEPTH, 2, queue entries; power of two, minimum 2.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- redirect  input  1  branch/jump/trap redirect request
- redirect_pc  input  64  new fetch address for redirect or fence_i
- fence_i  input  1  flush the cache and restart at redirect_pc
- ic_pc  output  64  fetch address to the instruction cache
- ic_invalid  output  1  cache invalidate request
- ic_inst_valid  input  1  cache holds the instruction at ic_pc
- ic_inst  input  32  instruction bits; upper 16 bits are don't-care when compressed
- ic_inst_comp  input  1  instruction is 16-bit
- page_fault  input  1  MMU instruction page fault for ic_pc
- out_valid  output  1  queue head is valid
- out_ready  input  1  decode accepts the head
- out_pc  output  64  PC of the head entry
- out_inst  output  32  instruction of the head entry
- out_comp  output  1  head entry is compressed
- out_fault  output  1  head entry carries a page fault

Behaviour:
- Reset values:
  - pc = RESET_PC; queue empty, so out_valid = 0.
  - out_pc, out_inst, out_comp and out_fault = 0.
  - ic_invalid = 0; state = S_RUN.
- ic_pc is the pc register with bit 0 always forced to 0.
- States:
  - S_RUN: normal fetch.
  - S_FLUSH: one cycle; ic_invalid = 1.
  - S_FAULT: fetch halted after a fault.
- Push condition: state == S_RUN & ic_inst_valid & ~page_fault & count < QDEPTH & ~redirect & ~fence_i.
  - Writes {pc, ic_inst, ic_inst_comp, fault=0} at the tail.
  - pc <= pc + (ic_inst_comp ? 2 : 4), 64-bit wrap.
  - Latency: the pushed entry appears at out_* on the next cycle at the earliest.
- Full queue: when count == QDEPTH there is no push, even if a pop happens in the same cycle (conservative). pc holds.
- Pop: out_valid & out_ready removes the head. Simultaneous push and pop with count < QDEPTH leaves count unchanged.
- Fault, taken in S_RUN when page_fault & count < QDEPTH & ~redirect & ~fence_i:
  - Pushes {pc, 32'h0, 0, fault=1}.
  - Moves to S_FAULT; pc holds.
  - In S_FAULT there are no pushes; pops continue. Only redirect or fence_i leaves S_FAULT.
- Redirect (any state):
  - Queue cleared; a pop in the same cycle is ignored.
  - pc <= {redirect_pc[63:1], 1'b0}; state <= S_RUN.
  - The next push is the cycle after.
- fence_i (any state):
  - Queue cleared; pc <= {redirect_pc[63:1], 1'b0}; state <= S_FLUSH.
  - S_FLUSH drives ic_invalid = 1 for exactly one cycle, with no push, then returns to S_RUN.
  - If fence_i and redirect are both asserted, fence_i wins.
  - fence_i asserted while in S_FLUSH restarts S_FLUSH with the new pc.
- Queue pointers are log2(QDEPTH) bits and wrap naturally. count is log2(QDEPTH)+1 bits.
- out_* reflect the head entry combinationally from queue storage. out_valid = (count != 0).
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The queue is emptied. Storage contents are don't-care.
- Nothing is pushed while ic_inst_valid = 0; a cache miss simply stalls the PC.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t {pc[63:0], inst[31:0], comp, fault}.
  - State enum {S_RUN, S_FLUSH, S_FAULT}.
  - Constants INST_STEP_C = 2 and INST_STEP_N = 4.
- Sub-module fetch_queue:
  - Generic synchronous FIFO of fetch_entry_t, QDEPTH deep.
  - Ports: push, pop, flush, full, empty, head.
  - flush has priority over push and pop.

Test Plan:
- Sequential mix: reset, cache returns 32-bit, 16-bit, 32-bit at 0x1000, 0x1004, 0x1006, out_ready = 1.
  - Required: out_pc sequence 0x1000, 0x1004, 0x1006; pc reaches 0x100A; out_comp = 0, 1, 0.
- Backpressure: out_ready = 0, continuous hits.
  - Required: count saturates at 2, pc stops at 0x1008, no entry lost.
  - Then raise out_ready: entries drain in order and pc resumes.
- Redirect while full: queue full, redirect = 1 with redirect_pc = 0x2003.
  - Required next cycle: out_valid = 0, ic_pc = 0x2002.
  - First push after that has out_pc = 0x2002.
- fence_i: fence_i = 1, redirect_pc = 0x3000.
  - Required: ic_invalid high exactly one cycle, no push during it, next push has pc 0x3000.
  - With fence_i and redirect both asserted, ic_invalid still pulses.
- Page fault at pc 0x1008:
  - Required: one entry with out_fault = 1 and out_inst = 0, then no further pushes despite ic_inst_valid = 1.
  - redirect to 0x4000 resumes fetch.
- Reset mid-stream with 1 entry queued and pc = 0x1234:
  - Required: rst_n low gives out_valid = 0, ic_pc = 0x1000, ic_invalid = 0 before the next clock edge.
